// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer
//  Brief    : 8-bit UART transmitter with selectable baud rate (2400..19200)
//             and optional odd/even parity. A byte is taken on a
//             tx_valid/tx_ready handshake and sent LSB first on data_tx.
//             Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int BASE_DIV = 2604          // clocks per bit at baud_rate 2'b11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    output logic       data_tx,
    output logic       tx_active_flag,
    output logic       tx_done_flag
);

    // Counter must reach BASE_DIV*8-1 (slowest rate, 2400 baud).
    localparam int              c_cnt_w = $clog2(BASE_DIV * 8);
    // One extra bit so the shifted period itself never wraps.
    localparam logic [c_cnt_w:0] c_base  = (c_cnt_w + 1)'(BASE_DIV);
    localparam logic [c_cnt_w:0] c_one   = (c_cnt_w + 1)'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,    w_cnt_nxt;
    logic [2:0]           r_idx,    w_idx_nxt;
    logic [7:0]           r_data,   w_data_nxt;
    logic [1:0]           r_baud,   w_baud_nxt;
    logic [1:0]           r_par,    w_par_nxt;
    logic                 r_tx,     w_tx_nxt;
    logic                 r_done,   w_done_nxt;
`ifdef UART_TX_TWO_STOP_EN
    logic                 r_stop2,  w_stop2_nxt;   // high while in the second stop bit
`endif

    logic [c_cnt_w:0]     w_period;
    logic [c_cnt_w:0]     w_last;
    logic                 w_bit_end;
    logic [2:0]           w_idx_inc;
    logic                 w_par_bit;
    logic                 w_par_en;

    // Bit period derived from the rate latched with the current byte.
    always_comb begin
        w_period  = c_base << (2'd3 - r_baud);
        w_last    = w_period - c_one;
        w_bit_end = ({1'b0, r_cnt} == w_last);
        w_idx_inc = r_idx + 3'd1;
        w_par_en  = (r_par == 2'b01) || (r_par == 2'b10);
        w_par_bit = (r_par == 2'b01) ? ~^r_data : ^r_data;
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? '0 : r_cnt + c_cnt_w'(1);
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_baud_nxt  = r_baud;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        w_stop2_nxt = r_stop2;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = 3'd0;
                w_tx_nxt  = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                w_stop2_nxt = 1'b0;
`endif
                if (tx_valid) begin
                    w_data_nxt  = tx_data;
                    w_baud_nxt  = baud_rate;
                    w_par_nxt   = parity_type;
                    w_tx_nxt    = 1'b0;          // start bit on the next cycle
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_data[0];
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx == 3'd7) begin
                        if (w_par_en) begin
                            w_tx_nxt    = w_par_bit;
                            w_state_nxt = PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = STOP;
                        end
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_tx_nxt  = r_data[w_idx_inc];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!r_stop2) begin
                        w_stop2_nxt = 1'b1;
                    end else begin
                        w_stop2_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
`else
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
`endif
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_data  <= 8'h00;
            r_baud  <= 2'b00;
            r_par   <= 2'b00;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2 <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_baud  <= w_baud_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2 <= w_stop2_nxt;
`endif
        end
    end

    assign tx_ready       = (r_state == IDLE);
    assign tx_active_flag = (r_state != IDLE);
    assign data_tx        = r_tx;
    assign tx_done_flag   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_serializer
//  Brief    : Directed self-checking bench for uart_tx_serializer (BASE_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

`ifdef UART_TX_TWO_STOP_EN
    localparam int c_stop_bits = 2;
`else
    localparam int c_stop_bits = 1;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       data_tx;
    logic       tx_active_flag;
    logic       tx_done_flag;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_serializer #(.BASE_DIV(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .baud_rate      (baud_rate),
        .parity_type    (parity_type),
        .data_tx        (data_tx),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; everything happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle cycles: line high, nothing active, no done pulse.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            chk("idle_line", {7'd0, data_tx}, 8'h01);
            chk("idle_done", {7'd0, tx_done_flag}, 8'h00);
            tick();
        end
    endtask

    // Send one byte and check every clock of its frame, then the done cycle.
    // With hold set, tx_valid stays high and tx_data switches to next_d.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] par,
                              input logic [1:0] baud, input int n,
                              input bit hold, input logic [7:0] next_d);
        logic [15:0] bits;
        int          nbits;
        bits  = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nbits = 9;
        if (par == 2'b01) begin
            bits[9] = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
            nbits = 10;
        end else if (par == 2'b10) begin
            bits[9] = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
            nbits = 10;
        end
        nbits = nbits + c_stop_bits;

        chk("ready_before", {7'd0, tx_ready}, 8'h01);
        tx_data     = d;
        parity_type = par;
        baud_rate   = baud;
        tx_valid    = 1'b1;
        tick();
        if (hold) begin
            tx_data = next_d;
        end else begin
            // Scramble inputs: the frame in flight must not notice.
            tx_valid    = 1'b0;
            tx_data     = d ^ 8'hFF;
            parity_type = ~par;
            baud_rate   = ~baud;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int j = 0; j < n; j++) begin
                chk($sformatf("bit%0d_c%0d", b, j), {7'd0, data_tx}, {7'd0, bits[b]});
                chk("active", {7'd0, tx_active_flag}, 8'h01);
                chk("done_early", {7'd0, tx_done_flag}, 8'h00);
                if (b == 0 && j == 0) chk("ready_busy", {7'd0, tx_ready}, 8'h00);
                tick();
            end
        end
        chk("done_pulse", {7'd0, tx_done_flag}, 8'h01);
        chk("done_line", {7'd0, data_tx}, 8'h01);
        chk("done_inactive", {7'd0, tx_active_flag}, 8'h00);
    endtask

    initial begin
        logic [7:0] d96;
        reset       = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        baud_rate   = 2'b11;
        parity_type = 2'b00;
        tick();
        tick();
        chk("rst_line", {7'd0, data_tx}, 8'h01);
        chk("rst_ready", {7'd0, tx_ready}, 8'h01);
        chk("rst_active", {7'd0, tx_active_flag}, 8'h00);
        chk("rst_done", {7'd0, tx_done_flag}, 8'h00);
        reset = 1'b0;
        idle(2);

        // Even parity, 11 bits x 4 clocks.
        send_frame(8'h55, 2'b10, 2'b11, 4, 1'b0, 8'h00);
        tick();
        idle(1);
        // Odd parity, then the same byte with no parity.
        send_frame(8'h07, 2'b01, 2'b11, 4, 1'b0, 8'h00);
        tick();
        idle(3);
        send_frame(8'h07, 2'b00, 2'b11, 4, 1'b0, 8'h00);
        tick();
        idle(2);

        // Back-to-back with tx_valid held: second accept happens in the done cycle.
        send_frame(8'hA5, 2'b10, 2'b11, 4, 1'b1, 8'h3C);
        send_frame(8'h3C, 2'b10, 2'b11, 4, 1'b0, 8'h00);
        tick();
        idle(2);

        // 0x00 at N=4; inputs change to 0xFF / baud 00 mid-frame, next frame at N=32.
        send_frame(8'h00, 2'b00, 2'b11, 4, 1'b0, 8'h00);
        tick();
        idle(1);
        send_frame(8'hFF, 2'b00, 2'b00, 32, 1'b0, 8'h00);
        tick();
        idle(2);

        // Reset during data bit 3.
        d96         = 8'h96;
        tx_data     = d96;
        baud_rate   = 2'b11;
        parity_type = 2'b00;
        tx_valid    = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("mr_start", {7'd0, data_tx}, 8'h00);
            tick();
        end
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 4; j++) begin
                chk("mr_data", {7'd0, data_tx}, {7'd0, d96[b]});
                tick();
            end
        end
        chk("mr_bit3", {7'd0, data_tx}, {7'd0, d96[3]});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_line", {7'd0, data_tx}, 8'h01);
        chk("mr_ready", {7'd0, tx_ready}, 8'h01);
        chk("mr_active", {7'd0, tx_active_flag}, 8'h00);
        chk("mr_done", {7'd0, tx_done_flag}, 8'h00);
        idle(6);

        // Reset wins over a simultaneous tx_valid.
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        tx_valid = 1'b0;
        chk("rp_active", {7'd0, tx_active_flag}, 8'h00);
        chk("rp_line", {7'd0, data_tx}, 8'h01);
        tick();
        chk("rp_active2", {7'd0, tx_active_flag}, 8'h00);
        idle(1);

        // Normal frame after reset.
        send_frame(8'hC3, 2'b01, 2'b11, 4, 1'b0, 8'h00);
        tick();
        chk("final_done_low", {7'd0, tx_done_flag}, 8'h00);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
